// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rsa_pkg
//  Description : Shared types and constants for the RSA exponentiation
//                control path. Holds the sequencer state encoding and the
//                command opcodes driven on op_sq.
//  Revision    : 1.0  initial release
// ============================================================================
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SQ   = 3'd2,
        MUL  = 3'd3,
        WAIT = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic OP_SQUARE = 1'b1;
    localparam logic OP_MULT   = 1'b0;

endpackage
`default_nettype wire

// File: rtl/msb_index.sv
`default_nettype none
// ============================================================================
//  Module      : msb_index
//  Description : Combinational highest-set-bit encoder. idx_o is the index
//                of the most significant 1 in vec_i; 0 when vec_i is zero
//                (callers treat the all-zero case separately).
//  Ports       : vec_i [W-1:0]  input vector
//                idx_o [IW-1:0] index of highest set bit
//  Revision    : 1.0  initial release
// ============================================================================
module msb_index #(
    parameter int W  = 64,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  vec_i,
    output logic [IW-1:0] idx_o
);

    // Ascending scan: the last hit wins, which is the highest set bit.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < W; i++) begin
            if (vec_i[i]) begin
                idx_o = IW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/exp_bit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : exp_bit_sequencer
//  Description : Iteration controller for left-to-right square-and-multiply
//                modular exponentiation. Latches the exponent on start, scans
//                it MSB-first and issues SQUARE / MULTIPLY commands to the
//                modular multiplier, one outstanding at a time.
//  Build macro : EXP_SKIP_LEADING_ZEROS_EN - when defined, scanning starts at
//                the highest set exponent bit; otherwise all EXP_W bits are
//                scanned (fixed SQUARE count, timing-uniform).
//  Ports       : clk       rising-edge clock
//                reset     synchronous active-low reset
//                start     begin a run (sampled in IDLE only)
//                exponent  EXP_W-bit exponent, sampled with start
//                op_valid  command valid to datapath
//                op_ready  datapath accepts command
//                op_sq     1 = SQUARE, 0 = MULTIPLY
//                op_first  first command of the run
//                op_done   accepted command finished (used in WAIT only)
//                bit_idx   exponent bit currently processed
//                busy      high in every state except IDLE
//                done      one-cycle end-of-run pulse
//  Revision    : 1.0  initial release
// ============================================================================
module exp_bit_sequencer
    import rsa_pkg::*;
#(
    parameter int EXP_W = 64,
    parameter int IDX_W = $clog2(EXP_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [EXP_W-1:0] exponent,
    output logic             op_valid,
    input  logic             op_ready,
    output logic             op_sq,
    output logic             op_first,
    input  logic             op_done,
    output logic [IDX_W-1:0] bit_idx,
    output logic             busy,
    output logic             done
);

    state_t           state_q,   state_d;
    logic [EXP_W-1:0] exp_q,     exp_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             first_q,   first_d;
    logic             pend_q,    pend_d;   // MULTIPLY owed for the current bit
    logic [IDX_W-1:0] load_idx;

`ifdef EXP_SKIP_LEADING_ZEROS_EN
    logic [IDX_W-1:0] msb_idx;

    msb_index #(
        .W  (EXP_W),
        .IW (IDX_W)
    ) u_msb_index (
        .vec_i (exp_q),
        .idx_o (msb_idx)
    );

    assign load_idx = msb_idx;
`else
    assign load_idx = IDX_W'(EXP_W - 1);
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            exp_q     <= '0;
            bit_idx_q <= '0;
            first_q   <= 1'b1;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            bit_idx_q <= bit_idx_d;
            first_q   <= first_d;
            pend_q    <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        bit_idx_d = bit_idx_q;
        first_d   = first_q;
        pend_d    = pend_q;
        op_valid  = 1'b0;
        op_sq     = OP_MULT;
        op_first  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    exp_d   = exponent;
                    first_d = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (exp_q == '0) begin
                    state_d = DONE;
                end else begin
                    bit_idx_d = load_idx;
                    state_d   = SQ;
                end
            end
            SQ: begin
                op_valid = 1'b1;
                op_sq    = OP_SQUARE;
                op_first = first_q;
                if (op_ready) begin
                    first_d = 1'b0;
                    pend_d  = exp_q[bit_idx_q];
                    state_d = WAIT;
                end
            end
            MUL: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    pend_d  = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (op_done) begin
                    if (pend_q) begin
                        state_d = MUL;
                    end else if (bit_idx_q == '0) begin
                        state_d = DONE;
                    end else begin
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                        state_d   = SQ;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bit_idx = bit_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_exp_bit_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exp_bit_sequencer
//  Description : Self-checking bench for exp_bit_sequencer (EXP_W = 8).
//                Expected command streams come from the square-and-multiply
//                rule applied to each exponent; the datapath responder raises
//                op_done three cycles after each accepted command.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_exp_bit_sequencer;

    localparam int EXP_W = 8;
    localparam int IDX_W = $clog2(EXP_W);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [EXP_W-1:0] exponent;
    logic             op_valid;
    logic             op_ready;
    logic             op_sq;
    logic             op_first;
    logic             op_done;
    logic [IDX_W-1:0] bit_idx;
    logic             busy;
    logic             done;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    typedef struct packed {
        logic             sq;
        logic             first;
        logic [IDX_W-1:0] idx;
    } cmd_t;

    exp_bit_sequencer #(.EXP_W(EXP_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .exponent (exponent),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_sq    (op_sq),
        .op_first (op_first),
        .op_done  (op_done),
        .bit_idx  (bit_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle(input string tag);
        check(tag, {op_valid, op_sq, op_first, busy, done, 29'(bit_idx)}, 32'h0);
    endtask

    // One complete run. stall_idx/stall_len hold op_ready low on one command
    // (with stray op_done pulses meanwhile); rnd_ready randomises op_ready;
    // restart_mid re-pulses start with 8'hFF; abort_after >= 0 applies reset
    // one cycle into the WAIT following that command.
    task automatic run(input logic [EXP_W-1:0] e, input int stall_idx, input int stall_len,
                       input bit rnd_ready, input bit restart_mid, input int abort_after);
        cmd_t q[$];
        cmd_t held;
        cmd_t cur;
        int   top;
        int   n = 0;
        int   cyc = 0;
        int   cnt = 0;
        int   stall_left = 0;
        bit   presented = 1'b0;
        bit   finished = 1'b0;
        bit   aborted = 1'b0;

        // Reference stream: square for each scanned bit, multiply for each 1.
`ifdef EXP_SKIP_LEADING_ZEROS_EN
        top = $clog2(int'(e) + 1) - 1;
`else
        top = (e == 0) ? -1 : EXP_W - 1;
`endif
        for (int i = top; i >= 0; i--) begin
            q.push_back('{sq: 1'b1, first: (i == top), idx: IDX_W'(i)});
            if (e[i]) q.push_back('{sq: 1'b0, first: 1'b0, idx: IDX_W'(i)});
        end

        @(negedge clk);
        start    = 1'b1;
        exponent = e;
        op_ready = 1'b0;
        op_done  = 1'b0;

        while (!finished && !aborted && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start    = 1'b0;
            op_ready = 1'b0;
            op_done  = 1'b0;
            if (restart_mid && cyc == 6) begin
                start    = 1'b1;
                exponent = 8'hFF;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) op_done = 1'b1;
            end
            if (cyc == 1) check("load_cycle", {busy, op_valid, done}, 3'b100);

            if (abort_after >= 0 && n == abort_after + 1 && cnt == 2) begin
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                check_idle("abort_idle");
                cnt = 0;
                aborted = 1'b1;
            end else if (done) begin
                check("cmd_count", n, q.size());
                check("done_in_wait", {presented, 1'b0, 30'(cnt)}, 32'h0);
                if (q.size() == 0) check("zero_done_lat", cyc, 2);
                finished = 1'b1;
            end else begin
                if (presented) check("valid_hold", op_valid, 1);
                if (op_valid) begin
                    check("one_outstanding", {cnt != 0, op_done}, 2'b00);
                    cur = '{sq: op_sq, first: op_first, idx: bit_idx};
                    if (n >= q.size()) begin
                        check("extra_cmd", n, q.size());
                        finished = 1'b1;
                    end else begin
                        if (!presented) begin
                            check("cmd_fields", cur, q[n]);
                            if (n == 0) check("first_lat", cyc, 2);
                            held       = cur;
                            presented  = 1'b1;
                            stall_left = (n == stall_idx) ? stall_len : 0;
                        end else begin
                            check("cmd_stable", cur, held);
                        end
                        if (stall_left > 0) begin
                            stall_left--;
                            op_done = 1'b1;   // stray: must be ignored in SQ/MUL
                        end else if (rnd_ready && $urandom_range(0, 2) == 0) begin
                            op_ready = 1'b0;
                        end else begin
                            op_ready  = 1'b1;
                            n++;
                            presented = 1'b0;
                            cnt       = 3;
                        end
                    end
                end
            end
        end

        if (!finished && !aborted) check("timeout", cyc, 0);
        if (finished) begin
            @(negedge clk);
            op_ready = 1'b0;
            op_done  = 1'b0;
            check("after_done", {busy, done, op_valid}, 3'b000);
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        exponent = '0;
        op_ready = 1'b0;
        op_done  = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        reset = 1'b1;

        // Stray op_done while idle.
        @(negedge clk);
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
        check_idle("idle_stray_done");

        run(8'h0B, -1, 0, 1'b0, 1'b0, -1);
        run(8'h00, -1, 0, 1'b0, 1'b0, -1);
        run(8'h0B,  1, 5, 1'b0, 1'b0, -1);
        run(8'h0B,  5, 3, 1'b0, 1'b0, -1);
        run(8'h0B, -1, 0, 1'b0, 1'b1, -1);
        run(8'h0B, -1, 0, 1'b0, 1'b0,  1);
        run(8'h0B, -1, 0, 1'b0, 1'b0, -1);
        run(8'h80, -1, 0, 1'b0, 1'b0, -1);
        run(8'h01, -1, 0, 1'b0, 1'b0, -1);

        for (int k = 0; k < 8; k++) begin
            run(8'($urandom), -1, 0, 1'b1, 1'b0, -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
